// File: rtl/tile_fetch_pkg.sv
// Shared phase constants, state encoding and slot decode for the tile fetch scheduler.
package tile_fetch_pkg;

  localparam logic [2:0] PH_CODE_A    = 3'd0;
  localparam logic [2:0] PH_CODE_L    = 3'd1;
  localparam logic [2:0] PH_ROM_A     = 3'd2;
  localparam logic [2:0] PH_ROM_L     = 3'd3;
  localparam logic [2:0] PH_CPU_FIRST = 3'd4;
  localparam logic [2:0] PH_CPU_LAST  = 3'd6;
  localparam logic [2:0] PH_LOAD      = 3'd7;

  typedef enum logic {
    BLANK  = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic logic is_cpu_phase(input logic [2:0] ph);
    return (ph >= PH_CPU_FIRST) && (ph <= PH_CPU_LAST);
  endfunction

endpackage

// File: rtl/tile_fetch_sched_slot.sv
// CPU side of the shared VRAM: grant qualification, one-clk ack and read data capture.
module vram_cpu_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_ce,
  input  logic              slot_active,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] vram_rdata,
  output logic              grant,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata
);

  logic              ack_q;
  logic              rd_q;
  logic [DATA_W-1:0] rdata_q;

  // The ack term stops a held request from being granted twice; reset kills an access in flight.
  assign grant = pix_ce & slot_active & cpu_req & ~ack_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q   <= 1'b0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= grant;
      rd_q  <= grant & ~cpu_we;
      if (ack_q && rd_q) begin
        rdata_q <= vram_rdata;
      end
    end
  end

  // Read data arrives from the RAM during the ack clk, so it is bypassed there and held afterwards.
  assign cpu_ack   = ack_q;
  assign cpu_rdata = (ack_q && rd_q) ? vram_rdata : rdata_q;

endmodule

// File: rtl/tile_fetch_sched.sv
// Per-cell scheduler sharing one synchronous VRAM between the tile fetch pipeline and the CPU.
module tile_fetch_sched
  import tile_fetch_pkg::*;
#(
  parameter int COL_W  = 5,
  parameter int ROW_W  = 5,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_ce,
  input  logic                hblank,
  input  logic                vblank,
  input  logic [COL_W-1:0]    tile_col,
  input  logic [ROW_W-1:0]    tile_row,
  input  logic [2:0]          line_in,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_ack,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic [ADDR_W-1:0]   vram_addr,
  output logic                vram_we,
  output logic [DATA_W-1:0]   vram_wdata,
  input  logic [DATA_W-1:0]   vram_rdata,
  output logic [DATA_W+2:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_data,
  output logic                sr_load_n,
  output logic [DATA_W-1:0]   sr_data
);

  state_e            state_q;
  logic [2:0]        phase_q;
  logic [DATA_W-1:0] code_q;
  logic [DATA_W-1:0] pattern_q;

  logic              blank_now;
  logic              slot_active;
  logic              grant;
  logic [ADDR_W-1:0] video_addr;

  assign blank_now = hblank | vblank;

  // Everything advances on pixel enables only; the latches are timed one phase after their address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BLANK;
      phase_q   <= PH_CODE_A;
      code_q    <= '0;
      pattern_q <= '0;
    end else if (pix_ce) begin
      case (state_q)
        BLANK: begin
          if (!blank_now) begin
            state_q <= ACTIVE;
            phase_q <= PH_CODE_A;
          end
        end
        ACTIVE: begin
          if (blank_now) begin
            state_q <= BLANK;
            phase_q <= PH_CODE_A;
          end else begin
            phase_q <= phase_q + 3'd1;
            if (phase_q == PH_CODE_L) begin
              code_q <= vram_rdata;
            end
            if (phase_q == PH_ROM_L) begin
              pattern_q <= rom_data;
            end
          end
        end
        default: begin
          state_q <= BLANK;
          phase_q <= PH_CODE_A;
        end
      endcase
    end
  end

  assign slot_active = (state_q == BLANK) | is_cpu_phase(phase_q);

  vram_cpu_slot #(
    .DATA_W(DATA_W)
  ) u_slot (
    .clk        (clk),
    .reset      (reset),
    .pix_ce     (pix_ce),
    .slot_active(slot_active),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .vram_rdata (vram_rdata),
    .grant      (grant),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata)
  );

  // The video address sits on the bus whenever the CPU does not own the current clk.
  assign video_addr = {tile_row, tile_col};
  assign vram_addr  = grant ? cpu_addr : video_addr;
  assign vram_we    = grant & cpu_we;
  assign vram_wdata = cpu_wdata;

  assign rom_addr  = {code_q, line_in};
  assign sr_load_n = ~((state_q == ACTIVE) && (phase_q == PH_LOAD) && pix_ce);
  assign sr_data   = pattern_q;

endmodule

// File: tb/tb_tile_fetch_sched.sv
// Directed bench for tile_fetch_sched with behavioural synchronous VRAM and character ROM.
module tb_tile_fetch_sched;

  logic        clk;
  logic        reset;
  logic        pix_ce;
  logic        hblank;
  logic        vblank;
  logic [4:0]  tile_col;
  logic [4:0]  tile_row;
  logic [2:0]  line_in;
  logic        cpu_req;
  logic        cpu_we;
  logic [9:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [9:0]  vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        sr_load_n;
  logic [7:0]  sr_data;

  logic [7:0]  vram [1024];
  logic [7:0]  rom  [2048];

  int checks;
  int passed;

  tile_fetch_sched dut (
    .clk       (clk),
    .reset     (reset),
    .pix_ce    (pix_ce),
    .hblank    (hblank),
    .vblank    (vblank),
    .tile_col  (tile_col),
    .tile_row  (tile_row),
    .line_in   (line_in),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .vram_addr (vram_addr),
    .vram_we   (vram_we),
    .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .sr_load_n (sr_load_n),
    .sr_data   (sr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM/ROM: data appears one clk after the address, reads return pre-write contents.
  always @(posedge clk) begin
    if (vram_we) vram[vram_addr] <= vram_wdata;
    vram_rdata <= vram[vram_addr];
    rom_data   <= rom[rom_addr];
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the clk whose registered phase is 0.
  task automatic start_line();
    hblank = 1'b1;
    cycle();
    hblank = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; hblank = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 10'h3FF; cpu_wdata = 8'hFF;
    repeat (3) cycle();
    #1;
    checks++; if (cpu_ack !== 1'b0) $display("[TB] FAIL reset_ack: got %h want 0", cpu_ack); else passed++;
    checks++; if (cpu_rdata !== 8'h00) $display("[TB] FAIL reset_rdata: got %h want 00", cpu_rdata); else passed++;
    checks++; if (sr_load_n !== 1'b1) $display("[TB] FAIL reset_load_n: got %h want 1", sr_load_n); else passed++;
    checks++; if (sr_data !== 8'h00) $display("[TB] FAIL reset_sr_data: got %h want 00", sr_data); else passed++;
    checks++; if (vram_we !== 1'b0) $display("[TB] FAIL reset_vram_we: got %h want 0", vram_we); else passed++;
    cpu_req = 1'b0;
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_fetch();
    tile_row = 5'd2; tile_col = 5'd3; line_in = 3'd5;
    start_line();
    #1;
    checks++; if (vram_addr !== 10'h043) $display("[TB] FAIL fetch_vaddr: got %h want 043", vram_addr); else passed++;
    checks++; if (vram_we !== 1'b0) $display("[TB] FAIL fetch_vwe: got %h want 0", vram_we); else passed++;
    cycle();
    cycle();
    #1;
    checks++; if (rom_addr !== 11'h20D) $display("[TB] FAIL fetch_rom_addr: got %h want 20d", rom_addr); else passed++;
    cycle();
    cycle();
    #1;
    checks++; if (sr_data !== 8'hA5) $display("[TB] FAIL fetch_sr_data_ph4: got %h want a5", sr_data); else passed++;
    checks++; if (sr_load_n !== 1'b1) $display("[TB] FAIL fetch_load_ph4: got %h want 1", sr_load_n); else passed++;
    repeat (3) cycle();
    #1;
    checks++; if (sr_load_n !== 1'b0) $display("[TB] FAIL fetch_load_ph7: got %h want 0", sr_load_n); else passed++;
    checks++; if (sr_data !== 8'hA5) $display("[TB] FAIL fetch_sr_data_ph7: got %h want a5", sr_data); else passed++;
    cycle();
    #1;
    checks++; if (sr_load_n !== 1'b1) $display("[TB] FAIL fetch_load_ph0: got %h want 1", sr_load_n); else passed++;
  endtask

  task automatic test_cpu_blank();
    hblank = 1'b1;
    cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h123; cpu_wdata = 8'h3C;
    #1;
    checks++; if (vram_we !== 1'b1) $display("[TB] FAIL blank_wr_we: got %h want 1", vram_we); else passed++;
    checks++; if (vram_addr !== 10'h123) $display("[TB] FAIL blank_wr_addr: got %h want 123", vram_addr); else passed++;
    checks++; if (vram_wdata !== 8'h3C) $display("[TB] FAIL blank_wr_data: got %h want 3c", vram_wdata); else passed++;
    checks++; if (cpu_ack !== 1'b0) $display("[TB] FAIL blank_wr_early_ack: got %h want 0", cpu_ack); else passed++;
    cycle();
    checks++; if (cpu_ack !== 1'b1) $display("[TB] FAIL blank_wr_ack: got %h want 1", cpu_ack); else passed++;
    checks++; if (vram_we !== 1'b0) $display("[TB] FAIL blank_wr_regrant: got %h want 0", vram_we); else passed++;
    cpu_req = 1'b0;
    cycle();
    checks++; if (cpu_ack !== 1'b0) $display("[TB] FAIL blank_wr_ack_len: got %h want 0", cpu_ack); else passed++;
    checks++; if (vram[10'h123] !== 8'h3C) $display("[TB] FAIL blank_wr_mem: got %h want 3c", vram[10'h123]); else passed++;
    cpu_req = 1'b1; cpu_we = 1'b0;
    #1;
    checks++; if (vram_addr !== 10'h123) $display("[TB] FAIL blank_rd_addr: got %h want 123", vram_addr); else passed++;
    checks++; if (vram_we !== 1'b0) $display("[TB] FAIL blank_rd_we: got %h want 0", vram_we); else passed++;
    cycle();
    checks++; if (cpu_ack !== 1'b1) $display("[TB] FAIL blank_rd_ack: got %h want 1", cpu_ack); else passed++;
    checks++; if (cpu_rdata !== 8'h3C) $display("[TB] FAIL blank_rd_data: got %h want 3c", cpu_rdata); else passed++;
    cpu_req = 1'b0;
    cycle();
    checks++; if (cpu_ack !== 1'b0) $display("[TB] FAIL blank_rd_ack_len: got %h want 0", cpu_ack); else passed++;
    checks++; if (cpu_rdata !== 8'h3C) $display("[TB] FAIL blank_rd_hold: got %h want 3c", cpu_rdata); else passed++;
  endtask

  task automatic test_req_phase0();
    start_line();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h200; cpu_wdata = 8'h5A;
    for (int p = 0; p < 4; p++) begin
      #1;
      checks++; if (vram_we !== 1'b0) $display("[TB] FAIL ph0_wait_we p%0d: got %h want 0", p, vram_we); else passed++;
      checks++; if (cpu_ack !== 1'b0) $display("[TB] FAIL ph0_wait_ack p%0d: got %h want 0", p, cpu_ack); else passed++;
      cycle();
    end
    #1;
    checks++; if (vram_we !== 1'b1) $display("[TB] FAIL ph4_grant_we: got %h want 1", vram_we); else passed++;
    checks++; if (vram_addr !== 10'h200) $display("[TB] FAIL ph4_grant_addr: got %h want 200", vram_addr); else passed++;
    cycle();
    checks++; if (cpu_ack !== 1'b1) $display("[TB] FAIL ph5_ack: got %h want 1", cpu_ack); else passed++;
    checks++; if (vram_we !== 1'b0) $display("[TB] FAIL ph5_no_regrant_we: got %h want 0", vram_we); else passed++;
    checks++; if (vram_addr !== 10'h043) $display("[TB] FAIL ph5_no_regrant_addr: got %h want 043", vram_addr); else passed++;
    cpu_req = 1'b0;
    cycle();
    checks++; if (cpu_ack !== 1'b0) $display("[TB] FAIL ph6_ack_len: got %h want 0", cpu_ack); else passed++;
  endtask

  task automatic test_grant_phase6();
    start_line();
    repeat (6) cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h200;
    #1;
    checks++; if (vram_addr !== 10'h200) $display("[TB] FAIL ph6_grant_addr: got %h want 200", vram_addr); else passed++;
    cycle();
    checks++; if (cpu_ack !== 1'b1) $display("[TB] FAIL ph7_ack: got %h want 1", cpu_ack); else passed++;
    checks++; if (cpu_rdata !== 8'h5A) $display("[TB] FAIL ph7_rdata: got %h want 5a", cpu_rdata); else passed++;
    checks++; if (sr_load_n !== 1'b0) $display("[TB] FAIL ph7_load: got %h want 0", sr_load_n); else passed++;
    checks++; if (sr_data !== 8'hA5) $display("[TB] FAIL ph7_sr_data: got %h want a5", sr_data); else passed++;
    checks++; if (vram_addr !== 10'h043) $display("[TB] FAIL ph7_video_addr: got %h want 043", vram_addr); else passed++;
    cycle();
    checks++; if (cpu_ack !== 1'b0) $display("[TB] FAIL ph0_single_ack: got %h want 0", cpu_ack); else passed++;
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_line();
    repeat (5) cycle();
    reset = 1'b1;
    repeat (3) cycle();
    #1;
    checks++; if (cpu_ack !== 1'b0) $display("[TB] FAIL mid_reset_ack: got %h want 0", cpu_ack); else passed++;
    checks++; if (cpu_rdata !== 8'h00) $display("[TB] FAIL mid_reset_rdata: got %h want 00", cpu_rdata); else passed++;
    checks++; if (sr_load_n !== 1'b1) $display("[TB] FAIL mid_reset_load_n: got %h want 1", sr_load_n); else passed++;
    checks++; if (sr_data !== 8'h00) $display("[TB] FAIL mid_reset_sr_data: got %h want 00", sr_data); else passed++;
    checks++; if (vram_we !== 1'b0) $display("[TB] FAIL mid_reset_vram_we: got %h want 0", vram_we); else passed++;
    reset = 1'b0;
    cycle();
    for (int p = 0; p < 8; p++) begin
      logic exp_load_n;
      exp_load_n = (p == 7) ? 1'b0 : 1'b1;
      #1;
      checks++; if (sr_load_n !== exp_load_n) $display("[TB] FAIL post_reset_phase p%0d: got %h want %h", p, sr_load_n, exp_load_n); else passed++;
      cycle();
    end
  endtask

  task automatic test_reset_grant();
    vblank = 1'b1;
    cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h300; cpu_wdata = 8'h77;
    #1;
    checks++; if (vram_we !== 1'b1) $display("[TB] FAIL rg_pre_we: got %h want 1", vram_we); else passed++;
    reset = 1'b1;
    cycle();
    checks++; if (cpu_ack !== 1'b0) $display("[TB] FAIL rg_no_ack: got %h want 0", cpu_ack); else passed++;
    checks++; if (vram_we !== 1'b0) $display("[TB] FAIL rg_we_after_reset: got %h want 0", vram_we); else passed++;
    cpu_req = 1'b0;
    reset = 1'b0;
    cycle();
    checks++; if (cpu_ack !== 1'b0) $display("[TB] FAIL rg_no_late_ack: got %h want 0", cpu_ack); else passed++;
    cpu_req = 1'b1;
    #1;
    checks++; if (vram_we !== 1'b1) $display("[TB] FAIL rg_rerequest_we: got %h want 1", vram_we); else passed++;
    cycle();
    checks++; if (cpu_ack !== 1'b1) $display("[TB] FAIL rg_rerequest_ack: got %h want 1", cpu_ack); else passed++;
    cpu_req = 1'b0;
    vblank = 1'b0;
    cycle();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    for (int i = 0; i < 1024; i++) vram[i] = 8'h00;
    for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
    vram[{5'd2, 5'd3}] = 8'h41;
    rom[{8'h41, 3'd5}] = 8'hA5;
    reset = 1'b1; pix_ce = 1'b1; hblank = 1'b1; vblank = 1'b0;
    tile_col = 5'd0; tile_row = 5'd0; line_in = 3'd0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'h000; cpu_wdata = 8'h00;

    test_reset();
    test_fetch();
    test_cpu_blank();
    test_req_phase0();
    test_grant_phase6();
    test_reset_mid();
    test_reset_grant();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
